// File: rtl/password_entry_controller_if.sv
// Button-pulse and display/status bundle between the pushbutton front end and the password controller.
// Latency: none (wiring only); the controller registers every output it drives here.
// Backpressure: none; buttons are fire-and-forget single-cycle pulses.
//
// Signals:
//   btn_u/btn_d/btn_l/btn_r/btn_c : single-cycle button pulses (button side -> controller)
//   digit0..digit3                : BCD digit values, digit3 leftmost (controller -> display)
//   selected_digit                : index of the digit being edited
//   unlocked/wrong/locked         : status flags
//   state                         : FSM state code, debug only
// Modports: master = button/display side, slave = controller.
interface password_entry_controller_if;
    logic       btn_u;
    logic       btn_d;
    logic       btn_l;
    logic       btn_r;
    logic       btn_c;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [1:0] selected_digit;
    logic       unlocked;
    logic       wrong;
    logic       locked;
    logic [2:0] state;

    modport master (
        output btn_u, btn_d, btn_l, btn_r, btn_c,
        input  digit0, digit1, digit2, digit3, selected_digit,
        input  unlocked, wrong, locked, state
    );

    modport slave (
        input  btn_u, btn_d, btn_l, btn_r, btn_c,
        output digit0, digit1, digit2, digit3, selected_digit,
        output unlocked, wrong, locked, state
    );
endinterface

// File: rtl/password_entry_controller.sv
// 4-digit BCD password entry FSM: edits digits from button pulses, checks the code, reports unlocked/wrong/locked.
// Latency: every action is visible one cycle after its button pulse; CHECK always lasts exactly one cycle.
// Backpressure: none; pulses that arrive while the FSM ignores buttons are dropped.
//
// Ports:
//   basys_clk : system clock, all logic on posedge
//   reset     : synchronous active-high reset
//   bus       : password_entry_controller_if.slave (button pulses in, digits/selection/status out)
// Optional feature: define LOCKOUT_EN to enable consecutive-failure counting and the LOCKOUT state.
module password_entry_controller #(
    parameter logic [15:0] PASSWORD       = 16'h1234,
    parameter int unsigned FAIL_HOLD      = 100000000,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
    input  logic                          basys_clk,
    input  logic                          reset,
    password_entry_controller_if.slave    bus
);

    // Reject configurations that would let a digit or a hold count go out of range.
    if (FAIL_HOLD < 1 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1 ||
        PASSWORD[3:0] > 4'd9 || PASSWORD[7:4] > 4'd9 ||
        PASSWORD[11:8] > 4'd9 || PASSWORD[15:12] > 4'd9) begin : g_param_check
        $error("password_entry_controller: illegal parameter value");
    end

`ifdef LOCKOUT_EN
    localparam int unsigned MAX_HOLD = (FAIL_HOLD > LOCKOUT_CYCLES) ? FAIL_HOLD : LOCKOUT_CYCLES;
`else
    localparam int unsigned MAX_HOLD = FAIL_HOLD;
`endif
    localparam int TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
    localparam logic [TW-1:0] FAIL_LAST = TW'(FAIL_HOLD - 1);

    typedef enum logic [2:0] {
        S_ENTRY    = 3'd0,
        S_CHECK    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_FAIL     = 3'd3
`ifdef LOCKOUT_EN
        ,S_LOCKOUT = 3'd4
`endif
    } state_t;

    state_t        r_state;
    logic [3:0]    r_digit [4];
    logic [1:0]    r_sel;
    logic          r_unlocked;
    logic          r_wrong;
    logic [TW-1:0] r_timer;

`ifdef LOCKOUT_EN
    localparam int FCW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS + 1) : 1;
    localparam logic [FCW-1:0] FC_MAX    = FCW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0]  LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
    logic [FCW-1:0] r_fail_count;
    logic           r_locked;
`endif

    logic [15:0] w_code;
    assign w_code = {r_digit[3], r_digit[2], r_digit[1], r_digit[0]};

    always_ff @(posedge basys_clk) begin
        if (reset) begin
            r_state    <= S_ENTRY;
            for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
            r_sel      <= 2'd0;
            r_unlocked <= 1'b0;
            r_wrong    <= 1'b0;
            r_timer    <= '0;
`ifdef LOCKOUT_EN
            r_fail_count <= '0;
            r_locked     <= 1'b0;
`endif
        end else begin
            // Free-running saturating hold timer; zeroed whenever a hold begins.
            if (r_timer != TIMER_MAX) r_timer <= r_timer + 1'b1;

            case (r_state)
                S_ENTRY: begin
                    // One button acts per cycle: c > u > d > l > r.
                    if (bus.btn_c) begin
                        r_state <= S_CHECK;
                    end else if (bus.btn_u) begin
                        r_digit[r_sel] <= (r_digit[r_sel] == 4'd9) ? 4'd0 : r_digit[r_sel] + 4'd1;
                    end else if (bus.btn_d) begin
                        r_digit[r_sel] <= (r_digit[r_sel] == 4'd0) ? 4'd9 : r_digit[r_sel] - 4'd1;
                    end else if (bus.btn_l) begin
                        r_sel <= r_sel + 2'd1;   // left = toward digit3, wraps 3 -> 0
                    end else if (bus.btn_r) begin
                        r_sel <= r_sel - 2'd1;   // right = toward digit0, wraps 0 -> 3
                    end
                end

                S_CHECK: begin
                    if (w_code == PASSWORD) begin
                        r_state    <= S_UNLOCKED;
                        r_unlocked <= 1'b1;
`ifdef LOCKOUT_EN
                        r_fail_count <= '0;
`endif
                    end else begin
                        r_state <= S_FAIL;
                        r_wrong <= 1'b1;
                        r_timer <= '0;
`ifdef LOCKOUT_EN
                        if (r_fail_count != FC_MAX) r_fail_count <= r_fail_count + 1'b1;
`endif
                    end
                end

                S_UNLOCKED: begin
                    if (bus.btn_c) begin
                        r_state    <= S_ENTRY;
                        r_unlocked <= 1'b0;
                        for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
                        r_sel      <= 2'd0;
                    end
                end

                S_FAIL: begin
                    // Timer was zeroed on entry, so FAIL lasts FAIL_HOLD cycles.
                    if (r_timer == FAIL_LAST) begin
                        r_wrong <= 1'b0;
                        for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
                        r_sel   <= 2'd0;
`ifdef LOCKOUT_EN
                        if (r_fail_count == FC_MAX) begin
                            r_state  <= S_LOCKOUT;
                            r_locked <= 1'b1;
                            r_timer  <= '0;
                        end else begin
                            r_state <= S_ENTRY;
                        end
`else
                        r_state <= S_ENTRY;
`endif
                    end
                end

`ifdef LOCKOUT_EN
                S_LOCKOUT: begin
                    if (r_timer == LOCK_LAST) begin
                        r_state      <= S_ENTRY;
                        r_locked     <= 1'b0;
                        r_fail_count <= '0;
                        for (int i = 0; i < 4; i++) r_digit[i] <= 4'd0;
                        r_sel        <= 2'd0;
                    end
                end
`endif

                default: r_state <= S_ENTRY;
            endcase
        end
    end

    assign bus.digit0         = r_digit[0];
    assign bus.digit1         = r_digit[1];
    assign bus.digit2         = r_digit[2];
    assign bus.digit3         = r_digit[3];
    assign bus.selected_digit = r_sel;
    assign bus.unlocked       = r_unlocked;
    assign bus.wrong          = r_wrong;
    assign bus.state          = r_state;
`ifdef LOCKOUT_EN
    assign bus.locked         = r_locked;
`else
    assign bus.locked         = 1'b0;
`endif

endmodule
